// File: rtl/door_arb_pkg.sv
// Shared types for the rolling-door command arbiter: FSM state codes and resolved command.
package door_arb_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    OPENING  = 3'd1,
    CLOSING  = 3'd2,
    DEADTIME = 3'd3,
    HOLD     = 3'd4,
    FAULT    = 3'd5
  } estado_t;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_OPEN  = 2'd1,
    CMD_CLOSE = 2'd2
  } cmd_t;

endpackage

// File: rtl/req_priority_enc.sv
// Fixed-priority request resolver: lowest index with exactly one of open/close set wins.
module req_priority_enc
  import door_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0] req_open,
  input  logic [NREQ-1:0] req_close,
  output cmd_t            cmd_c,
  output logic [NREQ-1:0] winner_c
);

  // Scan from the lowest priority up so the lowest valid index is the last write.
  always_comb begin
    cmd_c    = CMD_NONE;
    winner_c = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (req_open[i] ^ req_close[i]) begin
        winner_c    = '0;
        winner_c[i] = 1'b1;
        cmd_c       = req_open[i] ? CMD_OPEN : CMD_CLOSE;
      end
    end
  end

endmodule

// File: rtl/door_cmd_arbiter.sv
// Rolling-door motor arbiter: priority command select, reversal dead time, travel timeout,
// limit-sensor fault. Optional auto-close hold at the top limit under macro AUTO_CLOSE_EN.
module door_cmd_arbiter
  import door_arb_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned DEAD_CYCLES = 2,
  parameter int unsigned TRAVEL_MAX  = 16
`ifdef AUTO_CLOSE_EN
  ,
  parameter int unsigned HOLD_CYCLES = 8
`endif
) (
  input  logic            clk_2,
  input  logic            reset,
  input  logic [NREQ-1:0] req_open,
  input  logic [NREQ-1:0] req_close,
  input  logic            em_baixo,
  input  logic            em_cima,
  output logic            motor_abrindo,
  output logic            motor_fechando,
  output logic            alarme,
  output logic [NREQ-1:0] grant,
  output logic [2:0]      estado
);

  localparam int unsigned TW = $clog2(TRAVEL_MAX + 1);
  localparam int unsigned DW = $clog2(DEAD_CYCLES + 1);
`ifdef AUTO_CLOSE_EN
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam estado_t     TOP_STATE = HOLD;
`else
  localparam estado_t     TOP_STATE = IDLE;
`endif

  estado_t         state, state_n;
  cmd_t            cmd;
  logic [NREQ-1:0] winner;
  logic [NREQ-1:0] grant_n;
  logic [TW-1:0]   travel_cnt, travel_n, travel_inc;
  logic [DW-1:0]   dead_cnt, dead_n;
  logic            pend_open, pend_n;
`ifdef AUTO_CLOSE_EN
  logic [HW-1:0]   hold_cnt, hold_n;
`endif

  req_priority_enc #(.NREQ(NREQ)) u_enc (
    .req_open  (req_open),
    .req_close (req_close),
    .cmd_c     (cmd),
    .winner_c  (winner)
  );

  assign travel_inc = travel_cnt + TW'(1);
  assign estado     = state;

  // Next-state, counter and grant logic.
  always_comb begin
    state_n  = state;
    grant_n  = '0;
    travel_n = travel_cnt;
    dead_n   = dead_cnt;
    pend_n   = pend_open;
`ifdef AUTO_CLOSE_EN
    hold_n   = hold_cnt;
`endif
    case (state)
      IDLE: begin
        if (cmd == CMD_OPEN && !em_cima) begin
          state_n  = OPENING;
          grant_n  = winner;
          travel_n = '0;
        end else if (cmd == CMD_CLOSE && !em_baixo) begin
          state_n  = CLOSING;
          grant_n  = winner;
          travel_n = '0;
        end
      end
      OPENING: begin
        if (em_cima) begin
          state_n = TOP_STATE;
`ifdef AUTO_CLOSE_EN
          hold_n  = '0;
`endif
        end else if (travel_inc == TW'(TRAVEL_MAX)) begin
          state_n  = FAULT;
          travel_n = travel_inc;
        end else if (cmd == CMD_CLOSE) begin
          state_n = DEADTIME;
          grant_n = winner;
          pend_n  = 1'b0;
          dead_n  = '0;
        end else begin
          travel_n = travel_inc;
        end
      end
      CLOSING: begin
        if (em_baixo) begin
          state_n = IDLE;
        end else if (travel_inc == TW'(TRAVEL_MAX)) begin
          state_n  = FAULT;
          travel_n = travel_inc;
        end else if (cmd == CMD_OPEN) begin
          state_n = DEADTIME;
          grant_n = winner;
          pend_n  = 1'b1;
          dead_n  = '0;
        end else begin
          travel_n = travel_inc;
        end
      end
      DEADTIME: begin
        if (dead_cnt == DW'(DEAD_CYCLES - 1)) begin
          state_n  = pend_open ? OPENING : CLOSING;
          travel_n = '0;
        end else begin
          dead_n = dead_cnt + DW'(1);
        end
      end
`ifdef AUTO_CLOSE_EN
      HOLD: begin
        if (cmd == CMD_CLOSE) begin
          state_n  = CLOSING;
          grant_n  = winner;
          travel_n = '0;
        end else if (cmd == CMD_OPEN) begin
          grant_n = winner;
          hold_n  = '0;
        end else if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
          state_n  = CLOSING;
          travel_n = '0;
        end else begin
          hold_n = hold_cnt + HW'(1);
        end
      end
`endif
      FAULT: state_n = FAULT;
      default: state_n = IDLE;
    endcase
    // Contradictory limit sensors override any command.
    if (em_cima && em_baixo) begin
      state_n = FAULT;
      grant_n = '0;
    end
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state          <= IDLE;
      travel_cnt     <= '0;
      dead_cnt       <= '0;
      pend_open      <= 1'b0;
`ifdef AUTO_CLOSE_EN
      hold_cnt       <= '0;
`endif
      motor_abrindo  <= 1'b0;
      motor_fechando <= 1'b0;
      alarme         <= 1'b0;
      grant          <= '0;
    end else begin
      state          <= state_n;
      travel_cnt     <= travel_n;
      dead_cnt       <= dead_n;
      pend_open      <= pend_n;
`ifdef AUTO_CLOSE_EN
      hold_cnt       <= hold_n;
`endif
      motor_abrindo  <= (state_n == OPENING);
      motor_fechando <= (state_n == CLOSING);
      alarme         <= (state_n == FAULT);
      grant          <= grant_n;
    end
  end

endmodule
